keypad_scan_4x4: RTL and testbench

Scanner and debouncer for a 4x4 hex matrix keypad, the input-side counterpart of the 4-digit seven-segment output path. It drives keypad rows one at a time, samples the column lines, debounces a single pressed key, and outputs its 4-bit hex code. The hex code feeds the board-level operand registers, such as the ALU A/B inputs.

---
 rtl/keypad_pkg.sv | 22 ++
 rtl/keypad_tick_gen.sv | 36 +++
 rtl/keypad_scan_4x4.sv | 159 +++++++++++++++
 tb/tb_keypad_scan_4x4.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Key map, idle row drive and FSM state encoding.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } kp_state_t;

    localparam logic [3:0] ROW_IDLE = 4'b1110;

    // Raw index 4*row+col to hex code
    localparam logic [3:0] KEYMAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

endpackage

// File: rtl/keypad_tick_gen.sv
// Scan tick generator for the keypad scanner.
// Emits a one-cycle tick every SCAN_DIV clocks.
module keypad_tick_gen #(
    parameter int SCAN_DIV = 50000
) (
    input  logic sys_clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    // Wrap at the last count, otherwise increment
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (tick) begin
            cnt_d = '0;
        end
    end

    // Divider counter register
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_scan_4x4.sv
// 4x4 hex keypad scanner: row drive, column sync,
// single-key debounce and registered hex code output.
module keypad_scan_4x4
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic [3:0] Col_In,
    output logic [3:0] Row_Out,
    output logic [3:0] Key_Code,
    output logic       Key_Valid,
    output logic       Key_Held
);

    localparam int CNTW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CNTW-1:0] CNT_DONE = CNTW'(DEBOUNCE_CNT);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    logic            tick;
    logic [3:0]      sync1_q, sync2_q;
    kp_state_t       state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]      col_q, col_d;
    logic [1:0]      r_q, r_d;
    logic [3:0]      row_q, row_d;
    logic [3:0]      code_q, code_d;
    logic            valid_q, held_q, held_d;
    logic            key_present;
    logic [1:0]      pick;
    logic            adv, accept;

    keypad_tick_gen #(
        .SCAN_DIV(SCAN_DIV)
    ) u_tick (
        .sys_clk(sys_clk),
        .reset  (reset),
        .tick   (tick)
    );

    assign Row_Out   = row_q;
    assign Key_Code  = code_q;
    assign Key_Valid = valid_q;
    assign Key_Held  = held_q;

    // Lowest-index low column wins
    always_comb begin
        key_present = (sync2_q != 4'hF);
        pick        = 2'd0;
        priority case (1'b1)
            !sync2_q[0]: pick = 2'd0;
            !sync2_q[1]: pick = 2'd1;
            !sync2_q[2]: pick = 2'd2;
            !sync2_q[3]: pick = 2'd3;
            default:     pick = 2'd0;
        endcase
    end

    // Scan/debounce FSM next state, acting only on ticks
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        adv     = 1'b0;
        accept  = 1'b0;
        cnt_inc = cnt_q + 1'b1;
        if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (key_present) begin
                        col_d = pick;
                        cnt_d = CNT_ONE;
                        if (DEBOUNCE_CNT == 1) begin
                            accept  = 1'b1;
                            state_d = HELD;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        adv = 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (key_present && pick == col_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            accept  = 1'b1;
                            state_d = HELD;
                        end
                    end else begin
                        state_d = SCAN;
                        adv     = 1'b1;
                    end
                end
                HELD: begin
                    if (!key_present) begin
                        cnt_d = CNT_ONE;
                        if (DEBOUNCE_CNT == 1) begin
                            state_d = SCAN;
                            adv     = 1'b1;
                        end else begin
                            state_d = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (!key_present) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            state_d = SCAN;
                            adv     = 1'b1;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    // Row advance, code capture and held flag
    always_comb begin
        r_d    = adv ? r_q + 2'd1 : r_q;
        row_d  = adv ? ~(4'b0001 << r_d) : row_q;
        code_d = accept ? KEYMAP[{r_q, pick}] : code_q;
        held_d = (state_d == HELD) || (state_d == RELEASE);
    end

    // All state registers, including the column synchronizer
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
            state_q <= SCAN;
            cnt_q   <= '0;
            col_q   <= 2'd0;
            r_q     <= 2'd0;
            row_q   <= ROW_IDLE;
            code_q  <= 4'h0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            sync1_q <= Col_In;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            r_q     <= r_d;
            row_q   <= row_d;
            code_q  <= code_d;
            valid_q <= accept;
            held_q  <= held_d;
        end
    end

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Self-checking bench for keypad_scan_4x4.
// Tick-level reference model plus directed and random key scenarios.
module tb_keypad_scan_4x4;

    localparam int SDIV = 4;
    localparam int DB   = 3;

    logic       sys_clk = 1'b0;
    logic       reset   = 1'b0;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keys = 16'h0;

    int n_cmp = 0;
    int n_bad = 0;
    int vcount = 0;
    int tcount = 0;

    int         m_row, m_streak, m_scol, m_rel;
    bit         m_held, m_valid;
    logic [3:0] m_code;

    keypad_scan_4x4 #(
        .SCAN_DIV    (SDIV),
        .DEBOUNCE_CNT(DB)
    ) dut (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .Col_In   (col_in),
        .Row_Out  (row_out),
        .Key_Code (key_code),
        .Key_Valid(key_valid),
        .Key_Held (key_held)
    );

    always #5 sys_clk = ~sys_clk;

    // Keypad: pressed key pulls its column low when its row is driven
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!row_out[r]) begin
                for (int c = 0; c < 4; c++) begin
                    if (keys[4*r+c]) col_in[c] = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] ref_code(input int idx);
        string s;
        byte   ch;
        s  = "123A456B789CE0FD";
        ch = s[idx];
        if (ch >= "A") return 4'(ch - 55);
        return 4'(ch - 48);
    endfunction

    task automatic model_init();
        m_row    = 0;
        m_streak = 0;
        m_scol   = 0;
        m_rel    = 0;
        m_held   = 0;
        m_valid  = 0;
        m_code   = 4'h0;
    endtask

    // One scan decision: streak of identical sightings, then release run
    task automatic model_tick();
        int seen;
        seen = -1;
        for (int c = 3; c >= 0; c--) begin
            if (keys[4*m_row+c]) seen = c;
        end
        m_valid = 0;
        if (!m_held) begin
            if (m_streak > 0) begin
                if (seen == m_scol) m_streak++;
                else begin
                    m_streak = 0;
                    m_row = (m_row + 1) % 4;
                end
            end else if (seen >= 0) begin
                m_scol   = seen;
                m_streak = 1;
            end else begin
                m_row = (m_row + 1) % 4;
            end
            if (m_streak == DB) begin
                m_valid  = 1;
                m_code   = ref_code(4*m_row + m_scol);
                m_held   = 1;
                m_streak = 0;
                m_rel    = 0;
            end
        end else begin
            if (seen < 0) m_rel++;
            else m_rel = 0;
            if (m_rel == DB) begin
                m_held = 0;
                m_rel  = 0;
                m_row  = (m_row + 1) % 4;
            end
        end
    endtask

    // Advance one scan period and compare against the model
    task automatic run_tick();
        logic [3:0] exp_row;
        for (int i = 0; i < SDIV - 1; i++) begin
            @(posedge sys_clk);
            #1;
            n_cmp++;
            if (key_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL idle_valid tick=%0d got %b want 0", tcount, key_valid);
            end
        end
        @(posedge sys_clk);
        model_tick();
        #1;
        tcount++;
        exp_row = 4'hF;
        exp_row[m_row] = 1'b0;
        n_cmp++;
        if (key_valid !== m_valid) begin
            n_bad++;
            $display("FAIL tick_valid tick=%0d got %b want %b", tcount, key_valid, m_valid);
        end
        n_cmp++;
        if (key_code !== m_code) begin
            n_bad++;
            $display("FAIL tick_code tick=%0d got %h want %h", tcount, key_code, m_code);
        end
        n_cmp++;
        if (key_held !== m_held) begin
            n_bad++;
            $display("FAIL tick_held tick=%0d got %b want %b", tcount, key_held, m_held);
        end
        n_cmp++;
        if (row_out !== exp_row) begin
            n_bad++;
            $display("FAIL tick_row tick=%0d got %b want %b", tcount, row_out, exp_row);
        end
        if (key_valid === 1'b1) vcount++;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) run_tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        n_cmp++;
        if ({row_out, key_code, key_valid, key_held} !== {4'b1110, 4'h0, 2'b00}) begin
            n_bad++;
            $display("FAIL reset_outputs got row=%b code=%h v=%b h=%b want 1110 0 0 0",
                     row_out, key_code, key_valid, key_held);
        end
        @(negedge sys_clk);
        reset = 1'b1;
        model_init();
    endtask

    task automatic test_press_5();
        int v0;
        keys = 16'h0;
        keys[5] = 1'b1;
        v0 = vcount;
        run_ticks(12);
        n_cmp++;
        if (vcount - v0 != 1) begin
            n_bad++;
            $display("FAIL press5_pulses got %0d want 1", vcount - v0);
        end
        n_cmp++;
        if (key_code !== 4'h5 || key_held !== 1'b1 || row_out !== 4'b1101) begin
            n_bad++;
            $display("FAIL press5_state got code=%h h=%b row=%b want 5 1 1101",
                     key_code, key_held, row_out);
        end
    endtask

    task automatic test_release_5();
        keys = 16'h0;
        run_ticks(2);
        n_cmp++;
        if (key_held !== 1'b1) begin
            n_bad++;
            $display("FAIL release5_early got held=%b want 1", key_held);
        end
        run_ticks(1);
        n_cmp++;
        if (key_held !== 1'b0 || row_out !== 4'b1011) begin
            n_bad++;
            $display("FAIL release5_done got h=%b row=%b want 0 1011", key_held, row_out);
        end
        run_ticks(2);
    endtask

    task automatic test_bounce_d();
        int v0;
        keys = 16'h0;
        for (int i = 0; i < 8 && m_row != 3; i++) run_tick();
        keys[15] = 1'b1;
        run_tick();
        keys = 16'h0;
        run_tick();
        v0 = vcount;
        n_cmp++;
        if (v0 != vcount || key_held !== 1'b0) begin
            n_bad++;
            $display("FAIL bounce_glitch got held=%b want 0", key_held);
        end
        keys[15] = 1'b1;
        run_ticks(12);
        n_cmp++;
        if (vcount - v0 != 1 || key_code !== 4'hD) begin
            n_bad++;
            $display("FAIL bounce_d got pulses=%0d code=%h want 1 D", vcount - v0, key_code);
        end
        keys = 16'h0;
        run_ticks(4);
    endtask

    task automatic test_release_glitch_0();
        int v0;
        keys = 16'h0;
        keys[13] = 1'b1;
        v0 = vcount;
        run_ticks(12);
        n_cmp++;
        if (vcount - v0 != 1 || key_code !== 4'h0) begin
            n_bad++;
            $display("FAIL press0 got pulses=%0d code=%h want 1 0", vcount - v0, key_code);
        end
        keys = 16'h0;
        run_tick();
        keys[13] = 1'b1;
        v0 = vcount;
        run_ticks(6);
        n_cmp++;
        if (vcount != v0 || key_held !== 1'b1) begin
            n_bad++;
            $display("FAIL rel_glitch got pulses=%0d held=%b want 0 1", vcount - v0, key_held);
        end
        keys = 16'h0;
        run_ticks(4);
    endtask

    task automatic test_same_row_7_9();
        int v0;
        keys = 16'h0;
        keys[8]  = 1'b1;
        keys[10] = 1'b1;
        v0 = vcount;
        run_ticks(12);
        n_cmp++;
        if (vcount - v0 != 1 || key_code !== 4'h7) begin
            n_bad++;
            $display("FAIL same_row got pulses=%0d code=%h want 1 7", vcount - v0, key_code);
        end
        keys = 16'h0;
        run_ticks(4);
    endtask

    task automatic test_reset_mid_a();
        int v0;
        bit hit;
        keys = 16'h0;
        keys[3] = 1'b1;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            run_tick();
            if (m_streak == 2) hit = 1;
        end
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL reset_mid_reach got no debounce want streak 2");
        end
        @(posedge sys_clk);
        #1;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({row_out, key_code, key_valid, key_held} !== {4'b1110, 4'h0, 2'b00}) begin
            n_bad++;
            $display("FAIL reset_mid got row=%b code=%h v=%b h=%b want 1110 0 0 0",
                     row_out, key_code, key_valid, key_held);
        end
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        reset = 1'b1;
        model_init();
        v0 = vcount;
        run_ticks(2);
        n_cmp++;
        if (vcount != v0) begin
            n_bad++;
            $display("FAIL reset_mid_early got pulses=%0d want 0", vcount - v0);
        end
        run_ticks(1);
        n_cmp++;
        if (vcount - v0 != 1 || key_code !== 4'hA) begin
            n_bad++;
            $display("FAIL reset_mid_a got pulses=%0d code=%h want 1 A", vcount - v0, key_code);
        end
        keys = 16'h0;
        run_ticks(4);
    endtask

    task automatic test_random();
        int kind;
        for (int s = 0; s < 30; s++) begin
            kind = $urandom_range(0, 3);
            keys = 16'h0;
            if (kind >= 1) keys[$urandom_range(0, 15)] = 1'b1;
            if (kind == 3) keys[$urandom_range(0, 15)] = 1'b1;
            run_ticks($urandom_range(1, 9));
        end
        keys = 16'h0;
        run_ticks(5);
    endtask

    initial begin
        model_init();
        test_reset();
        test_press_5();
        test_release_5();
        test_bounce_d();
        test_release_glitch_0();
        test_same_row_7_9();
        test_reset_mid_a();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
